// File: rtl/y86_pkg.sv
// Y86-64 shared constants for the memory stage slice.
// Status codes, icodes, register ids and access classification.
package y86_pkg;

    localparam logic [3:0] S_BUB = 4'd0;
    localparam logic [3:0] S_AOK = 4'd1;
    localparam logic [3:0] S_HLT = 4'd2;
    localparam logic [3:0] S_ADR = 4'd3;
    localparam logic [3:0] S_INS = 4'd4;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } mstate_e;

    function automatic logic is_read(input logic [3:0] icode);
        return (icode == I_MRMOVQ) || (icode == I_POPQ) ||
               (icode == I_RET);
    endfunction

    function automatic logic is_write(input logic [3:0] icode);
        return (icode == I_RMMOVQ) || (icode == I_PUSHQ) ||
               (icode == I_CALL);
    endfunction

    // popq/ret address through valA (old %rsp), the rest through valE.
    function automatic logic addr_from_a(input logic [3:0] icode);
        return (icode == I_POPQ) || (icode == I_RET);
    endfunction

endpackage

// File: rtl/pipe_dmem.sv
// Byte-addressable little-endian data memory with word read/write.
// Ports: addr_i/we_i/wdata_i word access, rdata_o, in_range_o, pre_* byte preload.
module pipe_dmem #(
    parameter int DATA_W    = 64,
    parameter int MEM_BYTES = 1024
) (
    input  logic                         clk,
    input  logic [DATA_W-1:0]            addr_i,
    input  logic                         we_i,
    input  logic [DATA_W-1:0]            wdata_i,
    input  logic                         pre_we_i,
    input  logic [$clog2(MEM_BYTES)-1:0] pre_addr_i,
    input  logic [7:0]                   pre_data_i,
    output logic [DATA_W-1:0]            rdata_o,
    output logic                         in_range_o
);
    localparam int WB = DATA_W / 8;
    localparam int AW = $clog2(MEM_BYTES);
    localparam logic [DATA_W-1:0] LAST = DATA_W'(MEM_BYTES - WB);

    logic [7:0]    mem [MEM_BYTES];
    logic [AW-1:0] idx;

    // Compare against the last legal base directly; no addr+WB that could wrap.
    assign in_range_o = (addr_i <= LAST);
    assign idx        = addr_i[AW-1:0];

    always_comb begin
        rdata_o = '0;
        for (int i = 0; i < WB; i++) begin
            rdata_o[8*i +: 8] = mem[idx + AW'(i)];
        end
    end

    // Preload is applied last so it wins over a pipeline write to the same byte.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < WB; i++) begin
                mem[idx + AW'(i)] <= wdata_i[8*i +: 8];
            end
        end
        if (pre_we_i) begin
            mem[pre_addr_i] <= pre_data_i;
        end
    end

endmodule

// File: rtl/pipe_memory_stage.sv
// Y86-64 memory stage: wait-state FSM, data memory access and M->W register.
// Inputs: M_* bundle, W_stall/W_bubble, pre_* preload; outputs m_busy/m_stat/m_valM, W_*.
module pipe_memory_stage
    import y86_pkg::*;
#(
    parameter int DATA_W      = 64,
    parameter int MEM_BYTES   = 1024,
    parameter int MEM_LATENCY = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [3:0]                   M_stat,
    input  logic [3:0]                   M_icode,
    input  logic [DATA_W-1:0]            M_valE,
    input  logic [DATA_W-1:0]            M_valA,
    input  logic [3:0]                   M_dstE,
    input  logic [3:0]                   M_dstM,
    input  logic                         W_stall,
    input  logic                         W_bubble,
    input  logic                         pre_we,
    input  logic [$clog2(MEM_BYTES)-1:0] pre_addr,
    input  logic [7:0]                   pre_data,
    output logic                         m_busy,
    output logic [3:0]                   m_stat,
    output logic [DATA_W-1:0]            m_valM,
    output logic [3:0]                   W_stat,
    output logic [3:0]                   W_icode,
    output logic [3:0]                   W_dstE,
    output logic [3:0]                   W_dstM,
    output logic [DATA_W-1:0]            W_valE,
    output logic [DATA_W-1:0]            W_valM
);
    localparam int CW = (MEM_LATENCY > 0) ? $clog2(MEM_LATENCY + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LATENCY);

    logic              rd, wr, acc, in_range, done, mem_we;
    logic [DATA_W-1:0] addr, rdata;
    mstate_e           state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    assign rd   = is_read(M_icode);
    assign wr   = is_write(M_icode);
    assign addr = addr_from_a(M_icode) ? M_valA : M_valE;
    assign acc  = (rd || wr) && in_range;
    assign done = (cnt_q == CNT_LAST);

    assign m_busy = acc && !done;
    assign m_stat = ((rd || wr) && !in_range) ? S_ADR : M_stat;
    assign m_valM = (rd && in_range) ? rdata : '0;
    assign mem_we = wr && in_range && done && (M_stat == S_AOK) && !reset;

    pipe_dmem #(
        .DATA_W   (DATA_W),
        .MEM_BYTES(MEM_BYTES)
    ) u_dmem (
        .clk       (clk),
        .addr_i    (addr),
        .we_i      (mem_we),
        .wdata_i   (M_valA),
        .pre_we_i  (pre_we),
        .pre_addr_i(pre_addr),
        .pre_data_i(pre_data),
        .rdata_o   (rdata),
        .in_range_o(in_range)
    );

    always_comb begin
        cnt_d   = '0;
        state_d = ST_IDLE;
        unique case (state_q)
            ST_IDLE: begin
                if (m_busy) cnt_d = CW'(1);
            end
            ST_WAIT: begin
                if (m_busy) cnt_d = cnt_q + CW'(1);
            end
            default: cnt_d = '0;
        endcase
        if (cnt_d != '0) state_d = ST_WAIT;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            W_stat  <= S_BUB;
            W_icode <= I_NOP;
            W_valE  <= '0;
            W_valM  <= '0;
            W_dstE  <= RNONE;
            W_dstM  <= RNONE;
        end else if (W_stall) begin
            W_stat  <= W_stat;
        end else if (W_bubble || m_busy) begin
            W_stat  <= S_BUB;
            W_icode <= I_NOP;
            W_valE  <= '0;
            W_valM  <= '0;
            W_dstE  <= RNONE;
            W_dstM  <= RNONE;
        end else begin
            W_stat  <= m_stat;
            W_icode <= M_icode;
            W_valE  <= M_valE;
            W_valM  <= m_valM;
            W_dstE  <= M_dstE;
            W_dstM  <= M_dstM;
        end
    end

endmodule

// File: tb/tb_pipe_memory_stage.sv
// Directed bench for pipe_memory_stage: vector table on a zero-latency
// instance plus hand sequences on a two-wait-state instance.
module tb_pipe_memory_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  M_stat, M_icode, M_dstE, M_dstM;
    logic [63:0] M_valE, M_valA;
    logic        W_stall, W_bubble, pre_we;
    logic [9:0]  pre_addr;
    logic [7:0]  pre_data;

    logic        m_busy, b2;
    logic [3:0]  m_stat, W_stat, W_icode, W_dstE, W_dstM;
    logic [3:0]  ms2, ws2, wi2, wde2, wdm2;
    logic [63:0] m_valM, W_valE, W_valM;
    logic [63:0] mv2, wve2, wvm2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pipe_memory_stage #(.DATA_W(64), .MEM_BYTES(1024), .MEM_LATENCY(0)) u0 (
        .clk(clk), .reset(reset), .M_stat(M_stat), .M_icode(M_icode),
        .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM),
        .W_stall(W_stall), .W_bubble(W_bubble), .pre_we(pre_we),
        .pre_addr(pre_addr), .pre_data(pre_data), .m_busy(m_busy),
        .m_stat(m_stat), .m_valM(m_valM), .W_stat(W_stat),
        .W_icode(W_icode), .W_dstE(W_dstE), .W_dstM(W_dstM),
        .W_valE(W_valE), .W_valM(W_valM)
    );

    pipe_memory_stage #(.DATA_W(64), .MEM_BYTES(1024), .MEM_LATENCY(2)) u2 (
        .clk(clk), .reset(reset), .M_stat(M_stat), .M_icode(M_icode),
        .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM),
        .W_stall(W_stall), .W_bubble(W_bubble), .pre_we(pre_we),
        .pre_addr(pre_addr), .pre_data(pre_data), .m_busy(b2),
        .m_stat(ms2), .m_valM(mv2), .W_stat(ws2),
        .W_icode(wi2), .W_dstE(wde2), .W_dstM(wdm2),
        .W_valE(wve2), .W_valM(wvm2)
    );

    typedef struct {
        logic [3:0]  stat;
        logic [3:0]  icode;
        logic [63:0] valE;
        logic [63:0] valA;
        logic [3:0]  e_mstat;
        logic [63:0] e_valM;
    } vec_t;

    vec_t vec [13];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int a, input logic [7:0] d);
        pre_we   = 1'b1;
        pre_addr = 10'(a);
        pre_data = d;
        tick();
        pre_we   = 1'b0;
    endtask

    task automatic drive(input logic [3:0] st, input logic [3:0] ic,
                         input logic [63:0] e, input logic [63:0] a);
        M_stat  = st;
        M_icode = ic;
        M_valE  = e;
        M_valA  = a;
    endtask

    initial begin
        reset = 1'b1; W_stall = 1'b0; W_bubble = 1'b0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        drive(4'd1, 4'h1, 64'd0, 64'd0);
        M_dstE = 4'd2; M_dstM = 4'd3;

        vec[0]  = '{4'd1, 4'h5, 64'd10,   64'd0,   4'd1, 64'h0807060504030201};
        vec[1]  = '{4'd1, 4'h4, 64'd100,  64'hDEADBEEF, 4'd1, 64'd0};
        vec[2]  = '{4'd1, 4'hB, 64'd108,  64'd100, 4'd1, 64'hDEADBEEF};
        vec[3]  = '{4'd1, 4'h5, 64'd1050, 64'd0,   4'd3, 64'd0};
        vec[4]  = '{4'd1, 4'h5, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 4'd3, 64'd0};
        vec[5]  = '{4'd1, 4'h4, 64'd1017, 64'h1111, 4'd3, 64'd0};
        vec[6]  = '{4'd1, 4'h5, 64'd1016, 64'd0,   4'd1, 64'hA7A6A5A4A3A2A1A0};
        vec[7]  = '{4'd1, 4'h4, 64'd1016, 64'h1122334455667788, 4'd1, 64'd0};
        vec[8]  = '{4'd1, 4'h5, 64'd1016, 64'd0,   4'd1, 64'h1122334455667788};
        vec[9]  = '{4'd2, 4'h4, 64'd100,  64'd5,   4'd2, 64'd0};
        vec[10] = '{4'd1, 4'h5, 64'd100,  64'd0,   4'd1, 64'hDEADBEEF};
        vec[11] = '{4'd1, 4'h6, 64'd77,   64'd10,  4'd1, 64'd0};
        vec[12] = '{4'd1, 4'h9, 64'd18,   64'd10,  4'd1, 64'h0807060504030201};

        tick(); tick();
        reset = 1'b0;
        chk("rst W_stat", {60'd0, W_stat}, 64'd0);
        chk("rst W_icode", {60'd0, W_icode}, 64'd1);
        chk("rst W_dstE", {60'd0, W_dstE}, 64'hF);
        chk("rst W_valM", W_valM, 64'd0);
        chk("rst busy", {63'd0, m_busy}, 64'd0);

        for (int i = 0; i < 8; i++) preload(10 + i, 8'(i + 1));
        for (int i = 0; i < 8; i++) preload(1016 + i, 8'(8'hA0 + i));

        for (int i = 0; i < 13; i++) begin
            drive(vec[i].stat, vec[i].icode, vec[i].valE, vec[i].valA);
            #1;
            chk($sformatf("v%0d m_stat", i), {60'd0, m_stat},
                {60'd0, vec[i].e_mstat});
            chk($sformatf("v%0d m_valM", i), m_valM, vec[i].e_valM);
            chk($sformatf("v%0d m_busy", i), {63'd0, m_busy}, 64'd0);
            tick();
            chk($sformatf("v%0d W_stat", i), {60'd0, W_stat},
                {60'd0, vec[i].e_mstat});
            chk($sformatf("v%0d W_valM", i), W_valM, vec[i].e_valM);
            chk($sformatf("v%0d W_valE", i), W_valE, vec[i].valE);
        end

        // Preload beats a pipeline write to the same byte.
        drive(4'd1, 4'h4, 64'd300, 64'd0);
        pre_we = 1'b1; pre_addr = 10'd300; pre_data = 8'h99;
        tick();
        pre_we = 1'b0;
        drive(4'd1, 4'h5, 64'd300, 64'd0);
        #1;
        chk("pre prio", m_valM, 64'h99);

        // W stall then bubble on the zero-latency instance.
        drive(4'd1, 4'h5, 64'd10, 64'd0);
        M_dstE = 4'hF; M_dstM = 4'd5;
        tick();
        chk("ld W_dstM", {60'd0, W_dstM}, 64'd5);
        W_stall = 1'b1;
        drive(4'd1, 4'h5, 64'd1016, 64'd0);
        M_dstE = 4'd6; M_dstM = 4'd7;
        tick();
        chk("stall W_valM", W_valM, 64'h0807060504030201);
        chk("stall W_dstM", {60'd0, W_dstM}, 64'd5);
        chk("stall W_valE", W_valE, 64'd10);
        W_stall = 1'b0; W_bubble = 1'b1;
        tick();
        W_bubble = 1'b0;
        chk("bub W_stat", {60'd0, W_stat}, 64'd0);
        chk("bub W_dstE", {60'd0, W_dstE}, 64'hF);
        chk("bub W_icode", {60'd0, W_icode}, 64'd1);

        // Two-wait-state popq: two bubbles, result on the third edge.
        drive(4'd1, 4'h1, 64'd0, 64'd0);
        reset = 1'b1; tick(); reset = 1'b0;
        drive(4'd1, 4'hB, 64'd18, 64'd10);
        M_dstE = 4'd4; M_dstM = 4'd8;
        #1;
        chk("L2 busy c1", {63'd0, b2}, 64'd1);
        tick();
        chk("L2 W_stat e1", {60'd0, ws2}, 64'd0);
        chk("L2 W_icode e1", {60'd0, wi2}, 64'd1);
        chk("L2 busy c2", {63'd0, b2}, 64'd1);
        tick();
        chk("L2 W_stat e2", {60'd0, ws2}, 64'd0);
        chk("L2 busy c3", {63'd0, b2}, 64'd0);
        chk("L2 m_valM c3", mv2, 64'h0807060504030201);
        tick();
        drive(4'd1, 4'h1, 64'd0, 64'd0);
        chk("L2 W_stat e3", {60'd0, ws2}, 64'd1);
        chk("L2 W_valM e3", wvm2, 64'h0807060504030201);
        chk("L2 W_dstM e3", {60'd0, wdm2}, 64'd8);

        // Two-wait-state rmmovq aborted by reset in its second cycle.
        for (int i = 0; i < 8; i++) preload(200 + i, 8'h55);
        drive(4'd1, 4'h4, 64'd200, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(4'd1, 4'h1, 64'd0, 64'd0);
        #1;
        chk("rstW busy", {63'd0, b2}, 64'd0);
        chk("rstW W_stat", {60'd0, ws2}, 64'd0);
        chk("rstW W_icode", {60'd0, wi2}, 64'd1);
        chk("rstW W_dstE", {60'd0, wde2}, 64'hF);
        chk("rstW W_dstM", {60'd0, wdm2}, 64'hF);
        chk("rstW W_valE", wve2, 64'd0);
        chk("rstW W_valM", wvm2, 64'd0);
        tick(); tick();
        drive(4'd1, 4'h5, 64'd200, 64'd0);
        #1;
        chk("rstW mem", mv2, 64'h5555555555555555);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_memory_stage.md
Name: pipe_memory_stage

Overview:
- Parametrised Y86-64 memory stage with its M->W pipeline register.
- Holds a byte-addressable little-endian data memory and performs word reads and writes for memory instructions.
- Supports configurable wait-state latency with a busy/stall handshake to pipeline control.
- Detects out-of-bounds accesses (ADR status) and supports W-register stall and bubble.

Parameters:
- DATA_W, 64: word width in bits; WORD_BYTES = DATA_W/8.
- MEM_BYTES, 1024: data memory size in bytes.
- MEM_LATENCY, 0: wait states per in-range memory access (0 = single-cycle).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- M_stat  in  4  status of instruction in M.
- M_icode  in  4  opcode in M.
- M_valE  in  DATA_W  ALU result; address for rmmovq/mrmovq/pushq/call.
- M_valA  in  DATA_W  write data; address for popq/ret.
- M_dstE  in  4  E destination register.
- M_dstM  in  4  M destination register.
- W_stall  in  1  hold W register.
- W_bubble  in  1  load bubble into W.
- pre_we  in  1  preload byte write (test/boot).
- pre_addr  in  $clog2(MEM_BYTES)  preload byte address.
- pre_data  in  8  preload byte.
- m_busy  out  1  memory access in progress; upstream must hold M inputs stable.
- m_stat  out  4  combinational stage status.
- m_valM  out  DATA_W  combinational read data.
- W_stat, W_icode, W_dstE, W_dstM  out  4 each  W register.
- W_valE, W_valM  out  DATA_W  W register.

Behaviour:
- Status encoding: BUB=0, AOK=1, HLT=2, ADR=3, INS=4. RNONE=4'hF. NOP icode=1.
- Reads: mrmovq (5) from M_valE; popq (B) and ret (9) from M_valA.
- Writes: rmmovq (4), pushq (A) and call (8) to M_valE, with data M_valA.
- All other icodes: no access, m_valM=0.
- Bounds: an access is in range iff addr <= MEM_BYTES-WORD_BYTES. The compare is done in DATA_W width and must not wrap for addresses near 2^DATA_W.
- Out of range: dmem_error=1, m_stat=ADR, m_valM=0, no write, no wait states.
- Otherwise m_stat=M_stat.
- Writes are suppressed when M_stat!=AOK.
- Word byte i is located at addr+i (little-endian).
- FSM, IDLE/WAIT with counter cnt (0..MEM_LATENCY):
  - m_busy = (in-range memory access) && cnt != MEM_LATENCY.
  - While busy, cnt increments each cycle; the state is WAIT while cnt>0.
  - On the completion cycle (cnt==MEM_LATENCY): m_valM is valid, a write commits at the edge, and cnt returns to 0 (IDLE).
  - Access time is MEM_LATENCY+1 cycles. With MEM_LATENCY=0, m_busy is always 0.
- W register priority: reset > W_stall (hold) > W_bubble or m_busy (load bubble) > normal load.
- Normal load: W_stat=m_stat, W_icode=M_icode, W_valE=M_valE, W_valM=m_valM, W_dstE=M_dstE, W_dstM=M_dstM.
- Bubble / reset values: W_stat=BUB, W_icode=NOP, W_valE=W_valM=0, W_dstE=W_dstM=RNONE.
- Reset mid-WAIT: cnt=0, pending write is dropped, m_busy deasserts next cycle.
- Memory contents are not affected by reset.
- W_stall during WAIT: the counter still advances; the W register holds.
- Preload: writes pre_data to byte pre_addr at the edge. It has priority over a pipeline write to the same byte in the same cycle.

Decomposition:
- Shared package y86_pkg: status codes, icode constants, RNONE, NOP.
- Sub-module pipe_dmem: byte array, word read, bounds check, write and preload ports.
- pipe_memory_stage holds the FSM, counter and W register.

Test Plan:
- Preload bytes 10..17 = 01..08; mrmovq, M_valE=10 -> m_valM=64'h0807060504030201, W_valM the same after 1 edge, W_stat=AOK.
- rmmovq M_valE=100, M_valA=64'hDEADBEEF, then popq M_valA=100 -> m_valM=64'hDEADBEEF.
- mrmovq M_valE=1050 -> m_stat=ADR, m_valM=0, W_stat=ADR; rmmovq to 1017 -> ADR with memory unchanged; rmmovq to 1016 succeeds.
- MEM_LATENCY=2, popq in range -> m_busy high 2 cycles, W gets bubbles (W_stat=BUB, W_icode=NOP), result in W on the 3rd edge.
- MEM_LATENCY=2, rmmovq with reset asserted in cycle 2 -> target bytes unchanged, all W outputs at reset values, m_busy=0.
- W_stall=1 with a new valid mrmovq in M -> W holds its prior values; W_bubble=1 -> W_stat=BUB, W_dstE=F.
